// File: rtl/vga_pkg.sv
// Shared constants for the bouncing-block VGA generator.
//   - RGB565 colour constants used by the pixel priority mux
//   - block colour table (index = block number, lowest index drawn on top)
//   - saturating 16-bit accumulate helper for the reflection counter
package vga_pkg;

  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;

  localparam int MAX_BLK = 4;

  localparam logic [15:0] BLK_COLOR [MAX_BLK] = '{BLACK, RED, GREEN, MAGENTA};

  // Adds up to 15 to a 16-bit count, sticking at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/vga_bounce_multi_if.sv
// Pixel/control bundle between a video timing source and vga_bounce_multi.
//   pixel_xpos/pixel_ypos : current pixel coordinate (master -> slave)
//   move_pause            : freeze block motion (master -> slave)
//   speed_sel             : step per move tick minus one (master -> slave)
//   pixel_data            : registered RGB565 colour (slave -> master)
//   bounce_pulse          : one-cycle pulse after a tick with a reflection
//   bounce_cnt            : saturating reflection count
// There is no handshake: the slave accepts a coordinate every vga_clk cycle
// and presents its colour exactly one cycle later (always valid, always ready).
interface vga_bounce_multi_if;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic        move_pause;
  logic [1:0]  speed_sel;
  logic [15:0] pixel_data;
  logic        bounce_pulse;
  logic [15:0] bounce_cnt;

  modport master (
    output pixel_xpos, pixel_ypos, move_pause, speed_sel,
    input  pixel_data, bounce_pulse, bounce_cnt
  );

  modport slave (
    input  pixel_xpos, pixel_ypos, move_pause, speed_sel,
    output pixel_data, bounce_pulse, bounce_cnt
  );
endinterface

// File: rtl/vga_bounce_block.sv
// One bouncing square: holds its top-left position and travel directions,
// and on each enabled move steps both axes, clamping to the legal range and
// reversing an axis that reaches or would pass a bound.
//   vga_clk, sys_rst_n : clock, asynchronous active-low reset
//   i_move             : apply one step this cycle
//   i_step             : step size in pixels (1..4)
//   o_bx, o_by         : registered top-left corner
//   o_refl             : reflections the pending step would cause (0..2)
module vga_bounce_block
  import vga_pkg::*;
#(
  parameter int H_DISP  = 640,
  parameter int V_DISP  = 480,
  parameter int SIDE_W  = 40,
  parameter int BLOCK_W = 40,
  parameter int IDX     = 0
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       i_move,
  input  logic [2:0] i_step,
  output logic [9:0] o_bx,
  output logic [9:0] o_by,
  output logic [1:0] o_refl
);

  // 12-bit signed so a step below zero stays negative instead of wrapping.
  localparam logic signed [11:0] X_LO = 12'(SIDE_W);
  localparam logic signed [11:0] X_HI = 12'(H_DISP - SIDE_W - BLOCK_W);
  localparam logic signed [11:0] Y_LO = 12'(SIDE_W);
  localparam logic signed [11:0] Y_HI = 12'(V_DISP - SIDE_W - BLOCK_W);

  localparam logic [9:0] X_RST  = 10'(SIDE_W + 40 + 80 * IDX);
  localparam logic [9:0] Y_RST  = 10'(SIDE_W + 20 + 60 * IDX);
  localparam logic       XL_RST = (IDX % 2) != 0;

  logic [9:0] r_bx;
  logic [9:0] r_by;
  logic       r_x_left;
  logic       r_y_up;

  logic signed [11:0] w_nx;
  logic signed [11:0] w_ny;
  logic               w_x_hi;
  logic               w_x_lo;
  logic               w_y_hi;
  logic               w_y_lo;
  logic               w_flip_x;
  logic               w_flip_y;
  logic [9:0]         w_bx_nxt;
  logic [9:0]         w_by_nxt;

  always_comb begin
    w_nx = r_x_left ? $signed({2'b00, r_bx}) - $signed({9'd0, i_step})
                    : $signed({2'b00, r_bx}) + $signed({9'd0, i_step});
    w_ny = r_y_up   ? $signed({2'b00, r_by}) - $signed({9'd0, i_step})
                    : $signed({2'b00, r_by}) + $signed({9'd0, i_step});

    // Landing exactly on a bound counts as a hit, hence >= / <=.
    w_x_hi = (w_nx >= X_HI);
    w_x_lo = (w_nx <= X_LO);
    w_y_hi = (w_ny >= Y_HI);
    w_y_lo = (w_ny <= Y_LO);

    if (w_x_hi)      w_bx_nxt = X_HI[9:0];
    else if (w_x_lo) w_bx_nxt = X_LO[9:0];
    else             w_bx_nxt = w_nx[9:0];

    if (w_y_hi)      w_by_nxt = Y_HI[9:0];
    else if (w_y_lo) w_by_nxt = Y_LO[9:0];
    else             w_by_nxt = w_ny[9:0];

    w_flip_x = w_x_hi | w_x_lo;
    w_flip_y = w_y_hi | w_y_lo;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bx     <= X_RST;
      r_by     <= Y_RST;
      r_x_left <= XL_RST;
      r_y_up   <= 1'b0;
    end else if (i_move) begin
      r_bx     <= w_bx_nxt;
      r_by     <= w_by_nxt;
      r_x_left <= r_x_left ^ w_flip_x;
      r_y_up   <= r_y_up ^ w_flip_y;
    end
  end

  assign o_bx   = r_bx;
  assign o_by   = r_by;
  assign o_refl = {1'b0, w_flip_x} + {1'b0, w_flip_y};

endmodule

// File: rtl/vga_bounce_multi.sv
// Up to four coloured squares bouncing inside a blue border on a white field.
// A free-running divider produces a move tick every DIV_MAX cycles; on an
// unpaused tick every block steps by speed_sel+1 pixels. Reflections of each
// tick are summed into a pulse and a saturating counter. The colour of the
// requested pixel is registered, one cycle after its coordinate.
//   vga_clk   : sole clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : slave side of vga_bounce_multi_if (coordinates, pause,
//               speed select in; pixel_data, bounce_pulse, bounce_cnt out)
module vga_bounce_multi
  import vga_pkg::*;
#(
  parameter int H_DISP  = 640,
  parameter int V_DISP  = 480,
  parameter int SIDE_W  = 40,
  parameter int BLOCK_W = 40,
  parameter int N_BLK   = 4,
  parameter int DIV_MAX = 250000
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  vga_bounce_multi_if.slave bus
);

  localparam int              DIV_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

  localparam logic [9:0]  X_BL = 10'(SIDE_W);
  localparam logic [9:0]  X_BR = 10'(H_DISP - SIDE_W);
  localparam logic [9:0]  Y_BT = 10'(SIDE_W);
  localparam logic [9:0]  Y_BB = 10'(V_DISP - SIDE_W);
  localparam logic [10:0] BW11 = 11'(BLOCK_W);

  logic [DIV_W-1:0] r_div;
  logic             r_pulse;
  logic [15:0]      r_cnt;
  logic [15:0]      r_pix;

  logic        w_tick;
  logic        w_move;
  logic [2:0]  w_step;
  logic [3:0]  w_refl_sum;
  logic [15:0] w_pix;
  logic        w_border;

  logic [9:0]  w_bx   [N_BLK];
  logic [9:0]  w_by   [N_BLK];
  logic [1:0]  w_refl [N_BLK];

  // The divider keeps counting while paused; pause only masks the move.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                     r_div <= r_div + DIV_W'(1);
  end

  assign w_tick = (r_div == DIV_LAST);
  assign w_move = w_tick & ~bus.move_pause;
  assign w_step = {1'b0, bus.speed_sel} + 3'd1;

  for (genvar g = 0; g < N_BLK; g++) begin : g_blk
    vga_bounce_block #(
      .H_DISP (H_DISP),
      .V_DISP (V_DISP),
      .SIDE_W (SIDE_W),
      .BLOCK_W(BLOCK_W),
      .IDX    (g)
    ) u_blk (
      .vga_clk  (vga_clk),
      .sys_rst_n(sys_rst_n),
      .i_move   (w_move),
      .i_step   (w_step),
      .o_bx     (w_bx[g]),
      .o_by     (w_by[g]),
      .o_refl   (w_refl[g])
    );
  end

  // A corner hit contributes 2, so the total can reach 2*N_BLK.
  always_comb begin
    w_refl_sum = 4'd0;
    for (int i = 0; i < N_BLK; i++) begin
      w_refl_sum = w_refl_sum + {2'b00, w_refl[i]};
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pulse <= 1'b0;
      r_cnt   <= 16'd0;
    end else if (w_move) begin
      r_pulse <= (w_refl_sum != 4'd0);
      r_cnt   <= sat_add16(r_cnt, w_refl_sum);
    end else begin
      r_pulse <= 1'b0;
    end
  end

  // Walk blocks from highest index down so the lowest index overwrites last
  // and wins; the border overrides everything.
  always_comb begin
    w_border = (bus.pixel_xpos < X_BL) || (bus.pixel_xpos >= X_BR) ||
               (bus.pixel_ypos < Y_BT) || (bus.pixel_ypos >= Y_BB);
    w_pix = WHITE;
    for (int i = N_BLK - 1; i >= 0; i--) begin
      if (({1'b0, bus.pixel_xpos} >= {1'b0, w_bx[i]}) &&
          ({1'b0, bus.pixel_xpos} <  {1'b0, w_bx[i]} + BW11) &&
          ({1'b0, bus.pixel_ypos} >= {1'b0, w_by[i]}) &&
          ({1'b0, bus.pixel_ypos} <  {1'b0, w_by[i]} + BW11)) begin
        w_pix = BLK_COLOR[2'(i)];
      end
    end
    if (w_border) w_pix = BLUE;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_pix <= 16'h0000;
    else            r_pix <= w_pix;
  end

  assign bus.pixel_data   = r_pix;
  assign bus.bounce_pulse = r_pulse;
  assign bus.bounce_cnt   = r_cnt;

endmodule

// File: doc/vga_bounce_multi.md
VGA_BOUNCE_MULTI -- requirements
Module: vga_bounce_multi

Interface
REQ-001 Parameter H_DISP, default 640: active pixels per line.
REQ-002 Parameter V_DISP, default 480: active lines per frame.
REQ-003 Parameter SIDE_W, default 40: border width in pixels.
REQ-004 Parameter BLOCK_W, default 40: square block edge in pixels.
REQ-005 Parameter N_BLK, default 4, legal range 1..4: number of bouncing blocks.
REQ-006 Parameter DIV_MAX, default 250000: vga_clk cycles per move tick.
REQ-007 Port vga_clk, input, 1: sole clock.
REQ-008 Port sys_rst_n, input, 1: asynchronous active-low reset.
REQ-009 Port pixel_xpos, input, 10: current pixel column.
REQ-010 Port pixel_ypos, input, 10: current pixel row.
REQ-011 Port move_pause, input, 1: high freezes all block positions.
REQ-012 Port speed_sel, input, 2: step per tick = speed_sel+1 pixels.
REQ-013 Port pixel_data, output, 16: RGB565 colour, registered.
REQ-014 Port bounce_pulse, output, 1: one-cycle pulse on any reflection.
REQ-015 Port bounce_cnt, output, 16: saturating count of reflections.

Function
REQ-016 Divider counts 0..DIV_MAX-1 then wraps; move tick asserted on cycle where count = DIV_MAX-1; divider runs regardless of move_pause.
REQ-017 On tick with move_pause low, each block i moves step pixels along its x and y directions; step is speed_sel+1, sampled on the tick cycle.
REQ-018 On tick with move_pause high, positions, directions, bounce outputs unchanged.
REQ-019 Legal x range [SIDE_W, H_DISP-SIDE_W-BLOCK_W]; legal y range [SIDE_W, V_DISP-SIDE_W-BLOCK_W].
REQ-020 If the next coordinate would leave its legal range, coordinate clamps to the violated bound and that axis direction flips on the same tick; exact landing on a bound also flips.
REQ-021 Next-coordinate arithmetic uses at least 11 bits so subtraction below zero cannot wrap.
REQ-022 A corner hit (x and y both flip) counts as two reflections.
REQ-023 bounce_pulse high for exactly the cycle after a tick with ≥1 reflection; bounce_cnt adds total reflections of that tick (0..2*N_BLK), saturating at 16'hFFFF.
REQ-024 Pixel colour priority: border (x<SIDE_W, x≥H_DISP-SIDE_W, y<SIDE_W, y≥V_DISP-SIDE_W) BLUE 16'h001F > block 0 > block 1 > ... > background WHITE 16'hFFFF.
REQ-025 Pixel inside block i when x∈[bx_i, bx_i+BLOCK_W) and y∈[by_i, by_i+BLOCK_W).
REQ-026 Block colours: 0 BLACK 16'h0000, 1 RED 16'hF800, 2 GREEN 16'h07E0, 3 MAGENTA 16'hF81F.
REQ-027 pixel_data latency exactly one vga_clk from pixel_xpos/pixel_ypos.
REQ-028 Position used for pixel lookup is the registered position; an update mid-frame takes effect on the next cycle (no frame alignment).

Reset
REQ-029 Reset asynchronous on sys_rst_n low, released synchronously to vga_clk.
REQ-030 Reset values: divider 0, pixel_data 16'h0000, bounce_pulse 0, bounce_cnt 0.
REQ-031 Block i reset position x = SIDE_W+40+80*i, y = SIDE_W+20+60*i; x direction right for even i, left for odd i; y direction down.
REQ-032 Reset asserted mid-tick or mid-frame returns all state to REQ-030/031 values immediately.

Structure
REQ-033 Package vga_pkg holds RGB565 colour constants (BLUE, WHITE, BLACK, RED, GREEN, MAGENTA) and the block colour table.
REQ-034 One sub-module vga_bounce_block holds a single block's position, directions, clamp/flip logic and reflection count output; instantiated N_BLK times via generate.
REQ-035 Top holds divider, reflection summation/saturation and pixel priority mux.

Verification (DIV_MAX=4, defaults otherwise)
REQ-036 Reset release, speed_sel=0 -> block 0 at (80,60), moves to (81,61) 4 cycles after release; pixel (80,60) in -> 16'h0000 next cycle.
REQ-037 Block 0 forced near right edge x=558, speed_sel=3 -> next tick x=560, x direction left, bounce_pulse one cycle, bounce_cnt +1.
REQ-038 Block at (40,40) moving left/up -> stays (40,40), both directions flip, bounce_cnt +2.
REQ-039 move_pause high across 3 ticks -> positions and bounce_cnt constant; release -> movement resumes on next tick.
REQ-040 Blocks 0 and 1 overlapping at queried pixel -> 16'h0000; border pixel (5,200) -> 16'h001F; empty pixel -> 16'hFFFF.
REQ-041 bounce_cnt preloaded 16'hFFFE, two-reflection tick -> 16'hFFFF, no wrap.
